ansi_input_decoder: RTL and testbench
=====================================

// Module: ansi_input_decoder
// PURPOSE
//   Terminal-input side of the ANSI interface. Consumes the raw stdin byte stream and
//   decodes plain characters, arrow keys (ESC [ A..D), a bare ESC key (by timeout) and
//   cursor-position reports (ESC [ row ; col R). Sits between the stdin reader and the
//   game controller; one key event per output pulse.
// PARAMETERS
//   ESC_TIMEOUT  16  idle cycles after ESC/CSI with no byte before the sequence is closed
//   TMR_W        5   timer width; must hold ESC_TIMEOUT
// PORTS
//   clk        in   1  system clock, all state on posedge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  in_byte valid this cycle; always accepted, no backpressure
//   in_byte    in   8  raw terminal byte
//   key_valid  out  1  one-cycle pulse: key_code/key_char valid
//   key_code   out  4  KEY_CHAR=1, KEY_UP=2, KEY_DOWN=3, KEY_RIGHT=4, KEY_LEFT=5,
//                      KEY_ESC=6, KEY_ALT=7
//   key_char   out  8  byte for KEY_CHAR/KEY_ALT, else 0
//   cpr_valid  out  1  one-cycle pulse: cpr_row/cpr_col valid (ANSI_CPR_EN only)
//   cpr_row    out  8  reported row, holds last value
//   cpr_col    out  8  reported column, holds last value
//   err        out  1  one-cycle pulse: malformed or timed-out CSI sequence dropped
// BEHAVIOUR
//   - Reset: state GROUND; all outputs 0; params, index, timer cleared. Reset mid-sequence
//     discards the partial sequence, emits nothing.
//   - Latency: outputs registered; pulse appears the cycle after the final byte's in_valid.
//   - States: GROUND, ESC, CSI.
//   - GROUND: 0x1B -> ESC, timer=0. Any other byte -> KEY_CHAR, key_char=byte.
//   - ESC: '[' -> CSI, p0=p1=0, idx=0, timer=0. 0x1B -> emit KEY_ESC, stay ESC, timer=0.
//     Other byte -> emit KEY_ALT with key_char=byte, GROUND.
//   - CSI: '0'..'9' -> p[idx] = p[idx]*10 + digit, saturating at 255, timer=0.
//     ';' with idx=0 -> idx=1; with idx=1 -> err, GROUND. 'A','B','C','D' -> arrow key
//     (params ignored), GROUND. 'R' -> CPR (see CONFIGURATION), GROUND.
//     Any other byte -> err, GROUND (byte consumed, not re-emitted).
//   - Timer: in ESC/CSI, increments each cycle in_valid=0; reset to 0 on every byte.
//     When it reaches ESC_TIMEOUT: ESC -> emit KEY_ESC; CSI -> err; both -> GROUND.
//     Byte arriving on the expiry cycle wins: byte processed, no timeout action.
//   - CPR: param value 0 reported as 1 (ANSI default); missing col -> 1.
//   - At most one of key_valid/cpr_valid/err high per cycle.
// CONFIGURATION
//   ANSI_CPR_EN defined: 'R' final in CSI sets cpr_row=p0, cpr_col=p1, pulses cpr_valid.
//   Undefined: 'R' treated as unknown final -> err; cpr_valid, cpr_row, cpr_col tied 0;
//   param accumulator for p1 may be removed.
// STRUCTURE
//   - Shared package ansi_pkg: KEY_* codes, byte constants (ESC=0x1B, CSI '[', ';', SPACE=0x20),
//     state encodings; included by controller and this block.
//   - Sub-module ansi_param_acc: one decimal accumulator (clear, digit strobe, 8-bit
//     saturating value); instantiate two (p0, p1).
// TESTING
//   - ' ' then 'q' on consecutive cycles -> two KEY_CHAR pulses, key_char 0x20 then 0x71.
//   - 1B 5B 41, then 1B 5B 44 -> KEY_UP then KEY_LEFT, one cycle after each final byte.
//   - 1B alone, idle 16 cycles -> single KEY_ESC pulse; byte on expiry cycle -> KEY_ALT instead.
//   - "\033[24;80R" -> cpr_valid, row=24, col=80; "\033[R" -> row=1, col=1;
//     "\033[999;5R" -> row=255 (saturate); ANSI_CPR_EN undefined -> err only.
//   - "\033[1;2;3A" -> err on second ';', next byte 'x' -> KEY_CHAR 0x78.
//   - rst_n low after "\033[12" -> no pulses; next 'A' -> KEY_CHAR 0x41.

Source files
------------

// File: rtl/ansi_pkg.sv
// ansi_pkg -- shared definitions for the ANSI terminal interface.
//   KEY_* event codes, raw byte constants, decoder state encoding and
//   small byte-classification helpers. Imported by the input decoder and
//   the game controller.
package ansi_pkg;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_CHAR  = 4'd1;
    localparam logic [3:0] KEY_UP    = 4'd2;
    localparam logic [3:0] KEY_DOWN  = 4'd3;
    localparam logic [3:0] KEY_RIGHT = 4'd4;
    localparam logic [3:0] KEY_LEFT  = 4'd5;
    localparam logic [3:0] KEY_ESC   = 4'd6;
    localparam logic [3:0] KEY_ALT   = 4'd7;

    localparam logic [7:0] BYTE_ESC   = 8'h1B;
    localparam logic [7:0] BYTE_CSI   = 8'h5B;  // '['
    localparam logic [7:0] BYTE_SEMI  = 8'h3B;  // ';'
    localparam logic [7:0] BYTE_SPACE = 8'h20;
    localparam logic [7:0] BYTE_CPR   = 8'h52;  // 'R'

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_ESC,
        ST_CSI
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // CSI final byte to arrow key code; KEY_NONE when not an arrow final.
    function automatic logic [3:0] arrow_code(input logic [7:0] b);
        case (b)
            8'h41:   return KEY_UP;
            8'h42:   return KEY_DOWN;
            8'h43:   return KEY_RIGHT;
            8'h44:   return KEY_LEFT;
            default: return KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ansi_param_acc.sv
// ansi_param_acc -- one decimal CSI parameter accumulator.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   clear value to 0 (start of a new CSI sequence)
//   dig_stb  in   accumulate one decimal digit this cycle
//   digit    in   digit value 0..9 (low nibble of the ASCII digit)
//   value    out  8-bit value, saturates at 255
module ansi_param_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       dig_stb,
    input  logic [3:0] digit,
    output logic [7:0] value
);

    // 255*10+9 = 2559 fits in 12 bits, so the product never wraps.
    logic [11:0] next_val;
    assign next_val = ({4'd0, value} * 12'd10) + {8'd0, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (dig_stb) begin
            value <= (next_val > 12'd255) ? 8'hFF : next_val[7:0];
        end
    end

endmodule

// File: rtl/ansi_input_decoder.sv
// ansi_input_decoder -- decodes the raw stdin byte stream into key events.
//   Plain characters, arrow keys (ESC [ A..D), bare ESC by idle timeout,
//   Alt+key (ESC x) and cursor-position reports (ESC [ row ; col R).
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_byte   raw byte stream, always accepted
//   key_valid           one-cycle pulse, key_code/key_char valid
//   key_code, key_char  event code (ansi_pkg KEY_*) and byte for CHAR/ALT
//   cpr_valid           one-cycle pulse, cpr_row/cpr_col updated
//   cpr_row, cpr_col    last reported cursor position (hold)
//   err                 one-cycle pulse, malformed/timed-out CSI dropped
// Build option: define ANSI_CPR_EN to decode cursor-position reports;
// otherwise 'R' is an unknown CSI final and the cpr_* outputs are tied 0.
module ansi_input_decoder
    import ansi_pkg::*;
#(
    parameter int unsigned ESC_TIMEOUT = 16,
    parameter int unsigned TMR_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] key_char,
    output logic       cpr_valid,
    output logic [7:0] cpr_row,
    output logic [7:0] cpr_col,
    output logic       err
);

    // Timer fires on the idle cycle that would bring it to ESC_TIMEOUT.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ESC_TIMEOUT - 1);

    state_t           state, state_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic             idx, idx_d;
    logic             acc_clr, dig_stb;
    logic             kv_d, err_d;
    logic [3:0]       kc_d;
    logic [7:0]       kch_d;
    logic [7:0]       p0;
`ifdef ANSI_CPR_EN
    logic [7:0]       p1;
    logic             cv_d;
    logic [7:0]       row_d, col_d;
`endif

    ansi_param_acc u_p0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .dig_stb (dig_stb & ~idx),
        .digit   (in_byte[3:0]),
        .value   (p0)
    );

`ifdef ANSI_CPR_EN
    ansi_param_acc u_p1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .dig_stb (dig_stb & idx),
        .digit   (in_byte[3:0]),
        .value   (p1)
    );
`else
    // Parameters are only consumed by CPR; p0 is kept for the controller build.
    logic unused_p0;
    assign unused_p0 = ^p0;
`endif

    always_comb begin
        state_d = state;
        timer_d = timer;
        idx_d   = idx;
        acc_clr = 1'b0;
        dig_stb = 1'b0;
        kv_d    = 1'b0;
        kc_d    = KEY_NONE;
        kch_d   = '0;
        err_d   = 1'b0;
`ifdef ANSI_CPR_EN
        cv_d    = 1'b0;
        row_d   = cpr_row;
        col_d   = cpr_col;
`endif
        case (state)
            ST_GROUND: begin
                if (in_valid) begin
                    if (in_byte == BYTE_ESC) begin
                        state_d = ST_ESC;
                        timer_d = '0;
                    end else begin
                        kv_d  = 1'b1;
                        kc_d  = KEY_CHAR;
                        kch_d = in_byte;
                    end
                end
            end
            ST_ESC: begin
                if (in_valid) begin
                    timer_d = '0;
                    if (in_byte == BYTE_CSI) begin
                        state_d = ST_CSI;
                        acc_clr = 1'b1;
                        idx_d   = 1'b0;
                    end else if (in_byte == BYTE_ESC) begin
                        kv_d = 1'b1;
                        kc_d = KEY_ESC;
                    end else begin
                        kv_d    = 1'b1;
                        kc_d    = KEY_ALT;
                        kch_d   = in_byte;
                        state_d = ST_GROUND;
                    end
                end else if (timer == TMR_LAST) begin
                    kv_d    = 1'b1;
                    kc_d    = KEY_ESC;
                    state_d = ST_GROUND;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            ST_CSI: begin
                if (in_valid) begin
                    timer_d = '0;
                    if (is_digit(in_byte)) begin
                        dig_stb = 1'b1;
                    end else if (in_byte == BYTE_SEMI) begin
                        if (!idx) begin
                            idx_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_GROUND;
                        end
                    end else if (arrow_code(in_byte) != KEY_NONE) begin
                        kv_d    = 1'b1;
                        kc_d    = arrow_code(in_byte);
                        state_d = ST_GROUND;
                    end else if (in_byte == BYTE_CPR) begin
`ifdef ANSI_CPR_EN
                        // A zero/missing parameter means the ANSI default of 1.
                        cv_d  = 1'b1;
                        row_d = (p0 == 8'd0) ? 8'd1 : p0;
                        col_d = (p1 == 8'd0) ? 8'd1 : p1;
`else
                        err_d = 1'b1;
`endif
                        state_d = ST_GROUND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_GROUND;
                    end
                end else if (timer == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_GROUND;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            default: state_d = ST_GROUND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_GROUND;
            timer     <= '0;
            idx       <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_char  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            idx       <= idx_d;
            key_valid <= kv_d;
            key_code  <= kc_d;
            key_char  <= kch_d;
            err       <= err_d;
        end
    end

`ifdef ANSI_CPR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpr_valid <= 1'b0;
            cpr_row   <= '0;
            cpr_col   <= '0;
        end else begin
            cpr_valid <= cv_d;
            cpr_row   <= row_d;
            cpr_col   <= col_d;
        end
    end
`else
    assign cpr_valid = 1'b0;
    assign cpr_row   = '0;
    assign cpr_col   = '0;
`endif

endmodule

// File: tb/tb_ansi_input_decoder.sv
module tb_ansi_input_decoder;

    localparam logic [3:0] K_CHAR  = 4'd1;
    localparam logic [3:0] K_UP    = 4'd2;
    localparam logic [3:0] K_DOWN  = 4'd3;
    localparam logic [3:0] K_RIGHT = 4'd4;
    localparam logic [3:0] K_LEFT  = 4'd5;
    localparam logic [3:0] K_ESC   = 4'd6;
    localparam logic [3:0] K_ALT   = 4'd7;
    localparam int TIMEOUT = 16;
`ifdef ANSI_CPR_EN
    localparam bit CPR_EN = 1'b1;
`else
    localparam bit CPR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       key_valid, cpr_valid, err;
    logic [3:0] key_code;
    logic [7:0] key_char, cpr_row, cpr_col;
    logic [30:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ansi_input_decoder #(.ESC_TIMEOUT(16), .TMR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_char  (key_char),
        .cpr_valid (cpr_valid),
        .cpr_row   (cpr_row),
        .cpr_col   (cpr_col),
        .err       (err)
    );

    assign obs = {key_valid, key_code, key_char, cpr_valid, cpr_row, cpr_col, err};

    function automatic logic [30:0] pk(input logic [3:0] kc, input logic [7:0] kch,
                                       input logic cv, input logic [7:0] row,
                                       input logic [7:0] col, input logic er);
        return {kc != 4'd0, kc, kch, cv, row, col, er};
    endfunction

    task automatic chk(input string name, input logic [30:0] act, input logic [30:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (kv kc kch cv row col err)", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        in_valid = v;
        in_byte  = b;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic [30:0] exp;
    } vec_t;
    vec_t tbl[$];
    logic [7:0] cur_row = 8'd0;
    logic [7:0] cur_col = 8'd0;

    task automatic addq(input logic v, input logic [7:0] b);
        tbl.push_back('{v, b, pk(4'd0, 8'd0, 1'b0, cur_row, cur_col, 1'b0)});
    endtask
    task automatic addk(input logic [7:0] b, input logic [3:0] kc, input logic [7:0] kch);
        tbl.push_back('{1'b1, b, pk(kc, kch, 1'b0, cur_row, cur_col, 1'b0)});
    endtask
    task automatic adde(input logic [7:0] b);
        tbl.push_back('{1'b1, b, pk(4'd0, 8'd0, 1'b0, cur_row, cur_col, 1'b1)});
    endtask
    task automatic addc(input logic [7:0] row, input logic [7:0] col);
        if (CPR_EN) begin
            cur_row = row;
            cur_col = col;
            tbl.push_back('{1'b1, 8'h52, pk(4'd0, 8'd0, 1'b1, row, col, 1'b0)});
        end else begin
            adde(8'h52);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] seq[$];
    int idle = 0;
    int mrow = 0, mcol = 0;

    task automatic model(input logic v, input logic [7:0] b, output logic [30:0] e);
        logic [3:0] kc = 4'd0;
        logic [7:0] kch = 8'd0;
        logic cv = 1'b0, er = 1'b0;
        int semis = 0;
        int p[2];
        int k;
        if (v) begin
            idle = 0;
            if (seq.size() == 0) begin
                if (b == 8'h1B) seq.push_back(b);
                else begin kc = K_CHAR; kch = b; end
            end else if (seq.size() == 1) begin
                if (b == 8'h5B) seq.push_back(b);
                else if (b == 8'h1B) kc = K_ESC;
                else begin kc = K_ALT; kch = b; seq.delete(); end
            end else begin
                for (int i = 2; i < seq.size(); i++) if (seq[i] == 8'h3B) semis++;
                if (b >= 8'h30 && b <= 8'h39) seq.push_back(b);
                else if (b == 8'h3B && semis == 0) seq.push_back(b);
                else if (b >= 8'h41 && b <= 8'h44) begin
                    kc = K_UP + 4'(b - 8'h41);
                    seq.delete();
                end else if (b == 8'h52 && CPR_EN) begin
                    p[0] = 0; p[1] = 0; k = 0;
                    for (int i = 2; i < seq.size(); i++) begin
                        if (seq[i] == 8'h3B) k = 1;
                        else if (p[k] < 1000) p[k] = p[k] * 10 + int'(seq[i] - 8'h30);
                    end
                    for (int j = 0; j < 2; j++) begin
                        if (p[j] > 255) p[j] = 255;
                        if (p[j] == 0) p[j] = 1;
                    end
                    mrow = p[0]; mcol = p[1]; cv = 1'b1;
                    seq.delete();
                end else begin
                    er = 1'b1;
                    seq.delete();
                end
            end
        end else if (seq.size() > 0) begin
            idle++;
            if (idle == TIMEOUT) begin
                if (seq.size() == 1) kc = K_ESC;
                else er = 1'b1;
                seq.delete();
                idle = 0;
            end
        end
        e = pk(kc, kch, cv, 8'(mrow), 8'(mcol), er);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [30:0] idle_exp, e;
        logic [7:0] pool[16];
        int pulses, burst;

        // ----- reset state -----
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs, 31'd0);
        rst_n = 1'b1;

        // ----- table -----
        addk(8'h20, K_CHAR, 8'h20);
        addk(8'h71, K_CHAR, 8'h71);
        addq(1, 8'h1B); addq(1, 8'h5B); addk(8'h41, K_UP, 8'h00);
        addq(1, 8'h1B); addq(1, 8'h5B); addk(8'h44, K_LEFT, 8'h00);
        addq(0, 8'h00);
        addq(1, 8'h1B); addq(1, 8'h5B); addq(1, 8'h32); addq(1, 8'h34);
        addq(1, 8'h3B); addq(1, 8'h38); addq(1, 8'h30); addc(8'd24, 8'd80);
        addq(1, 8'h1B); addq(1, 8'h5B); addc(8'd1, 8'd1);
        addq(1, 8'h1B); addq(1, 8'h5B); addq(1, 8'h39); addq(1, 8'h39);
        addq(1, 8'h39); addq(1, 8'h3B); addq(1, 8'h35); addc(8'd255, 8'd5);
        addq(1, 8'h1B); addq(1, 8'h5B); addq(1, 8'h3B); addq(1, 8'h37); addc(8'd1, 8'd7);
        addq(1, 8'h1B); addq(1, 8'h5B); addq(1, 8'h31); addq(1, 8'h3B);
        addq(1, 8'h32); adde(8'h3B); addk(8'h78, K_CHAR, 8'h78);
        addq(1, 8'h1B); addk(8'h1B, K_ESC, 8'h00); addk(8'h61, K_ALT, 8'h61);
        addq(1, 8'h1B); addq(1, 8'h5B); addq(1, 8'h33); addq(0, 8'h00);
        addq(0, 8'h00); adde(8'h5A);
        addq(1, 8'h1B); addq(1, 8'h5B); addk(8'h42, K_DOWN, 8'h00);
        addq(1, 8'h1B); addq(1, 8'h5B); addq(1, 8'h35); addk(8'h43, K_RIGHT, 8'h00);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].b);
            chk($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        idle_exp = pk(4'd0, 8'd0, 1'b0, cur_row, cur_col, 1'b0);

        // ----- bare ESC by timeout -----
        step(1, 8'h1B);
        pulses = 0;
        repeat (TIMEOUT - 1) begin step(0, 8'h00); if (obs !== idle_exp) pulses++; end
        chk("esc_wait", 31'(pulses), 31'd0);
        step(0, 8'h00);
        chk("esc_timeout", obs, pk(K_ESC, 8'd0, 1'b0, cur_row, cur_col, 1'b0));
        step(0, 8'h00);
        chk("esc_after", obs, idle_exp);

        // ----- byte on expiry cycle wins -----
        step(1, 8'h1B);
        repeat (TIMEOUT - 1) step(0, 8'h00);
        step(1, 8'h78);
        chk("esc_expiry_byte", obs, pk(K_ALT, 8'h78, 1'b0, cur_row, cur_col, 1'b0));

        // ----- CSI timeout -> err; CSI expiry byte wins -----
        step(1, 8'h1B); step(1, 8'h5B);
        repeat (TIMEOUT - 1) step(0, 8'h00);
        step(0, 8'h00);
        chk("csi_timeout", obs, pk(4'd0, 8'd0, 1'b0, cur_row, cur_col, 1'b1));
        step(1, 8'h1B); step(1, 8'h5B);
        repeat (TIMEOUT - 1) step(0, 8'h00);
        step(1, 8'h43);
        chk("csi_expiry_byte", obs, pk(K_RIGHT, 8'd0, 1'b0, cur_row, cur_col, 1'b0));

        // ----- reset mid-sequence -----
        step(1, 8'h1B); step(1, 8'h5B); step(1, 8'h31); step(1, 8'h32);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", obs, 31'd0);
        step(0, 8'h00);
        chk("mid_reset_hold", obs, 31'd0);
        rst_n = 1'b1;
        step(1, 8'h41);
        chk("post_reset_char", obs, pk(K_CHAR, 8'h41, 1'b0, 8'd0, 8'd0, 1'b0));

        // ----- randomized vs model -----
        pool = '{8'h1B, 8'h1B, 8'h1B, 8'h5B, 8'h5B, 8'h30, 8'h31, 8'h35,
                 8'h39, 8'h3B, 8'h41, 8'h42, 8'h43, 8'h44, 8'h52, 8'h78};
        seq.delete(); idle = 0; mrow = 0; mcol = 0;
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            logic v;
            logic [7:0] b;
            int r;
            b = 8'h00;
            if (burst > 0) begin
                burst--;
                v = 1'b0;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 4) begin burst = $urandom_range(12, 18); v = 1'b0; end
                else if (r < 25) v = 1'b0;
                else begin v = 1'b1; b = pool[$urandom_range(0, 15)]; end
            end
            model(v, b, e);
            step(v, b);
            chk($sformatf("rnd%0d", n), obs, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
